// File: rtl/drive_gear_ctrl.sv
// drive_gear_ctrl: tick-paced speed/gear controller with lamp, steering and 7-segment outputs.
// Optional cruise-hold feature is built in when the DRIVE_CRUISE_EN macro is defined.
module drive_gear_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_GEARS  = 5,
  parameter int GEAR_STEP  = 5,
  parameter int ACC_STEP   = 3,
  parameter int COAST_STEP = 1,
  parameter int BRAKE_STEP = 3,
  parameter int TURN_LIMIT = 4,
  parameter int REV_MAX    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       brake,
  input  logic       acc,
  input  logic       gear,
  input  logic       l,
  input  logic       r,
  input  logic       hl,
`ifdef DRIVE_CRUISE_EN
  input  logic       cruise,
`endif
  output logic [6:0] speed,
  output logic [3:0] gear_o,
  output logic       E,
  output logic       TL,
  output logic       LH,
  output logic       RH,
  output logic       HL,
  output logic       AL,
  output logic [1:0] M2,
  output logic [3:0] AN,
  output logic [6:0] LED,
  output logic       tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FWD_MAX = NUM_GEARS * GEAR_STEP;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      speed_q, speed_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            blink_q, blink_d;
  logic            wrap;
  logic            dir_change;
  logic            cruise_act;
  int              sp;

  logic [3:0]      gear_q, gear_d;
  logic [6:0]      led_q, led_d;
  logic [3:0]      an_q, an_d;
  logic [1:0]      m2_q, m2_d;
  logic            e_q, e_d, tl_q, tl_d, lh_q, lh_d, rh_q, rh_d;
  logic            hl_q, hl_d, al_q, al_d, tick_q, tick_d;
  logic            lh_en, rh_en, turn_ok;
  logic [NUM_GEARS-1:0] at_gear;

`ifdef DRIVE_CRUISE_EN
  logic cruise_q, cruise_d, cruise_prev_q;

  // Cruise toggles on a rising edge only while moving forward; any override drops it.
  always_comb begin
    cruise_d = cruise_q;
    if (cruise && !cruise_prev_q)
      cruise_d = !cruise_q && (state_q == ST_FWD) && (speed_q != 7'd0);
    if (brake || !key || gear || (state_q != ST_FWD))
      cruise_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cruise_q      <= 1'b0;
      cruise_prev_q <= 1'b0;
    end else begin
      cruise_q      <= cruise_d;
      cruise_prev_q <= cruise;
    end
  end

  assign cruise_act = cruise_q;
`else
  assign cruise_act = 1'b0;
`endif

  always_comb begin
    wrap       = (cnt_q == CNT_LAST);
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    blink_d    = blink_q ^ wrap;
    tick_d     = wrap;
    state_d    = state_q;
    dir_change = 1'b0;
    sp         = int'(speed_q);
    if (wrap) begin
      if (!key) begin
        state_d = ST_PARK;
      end else begin
        case (state_q)
          ST_PARK: state_d = ST_FWD;
          ST_FWD:  if (gear && (speed_q == 7'd0)) state_d = ST_REV;
          ST_REV:  if (!gear && (speed_q == 7'd0)) state_d = ST_FWD;
          default: state_d = ST_PARK;
        endcase
      end
      // A direction change happens at standstill and consumes that tick.
      dir_change = ((state_q == ST_FWD) && (state_d == ST_REV)) ||
                   ((state_q == ST_REV) && (state_d == ST_FWD));
      if (!dir_change) begin
        case (state_d)
          ST_FWD: begin
            if (brake || gear)      sp = sp - BRAKE_STEP;
            else if (acc)           sp = (sp + ACC_STEP > FWD_MAX) ? FWD_MAX : sp + ACC_STEP;
            else if (!cruise_act)   sp = sp - COAST_STEP;
          end
          ST_REV: begin
            if (brake)              sp = sp - BRAKE_STEP;
            else if (acc)           sp = (sp + ACC_STEP > REV_MAX) ? REV_MAX : sp + ACC_STEP;
            else                    sp = sp - COAST_STEP;
          end
          default:                  sp = sp - BRAKE_STEP;
        endcase
        if (sp < 0) sp = 0;
      end
    end
    speed_d = 7'(sp);
  end

  // Thermometer of gear thresholds; its population count is the capped gear number.
  for (genvar gi = 0; gi < NUM_GEARS; gi++) begin : g_gear_thr
    assign at_gear[gi] = (speed_d >= 7'((gi + 1) * GEAR_STEP));
  end

  always_comb begin
    gear_d = (state_d == ST_REV) ? 4'd15 : 4'($countones(at_gear));
    case (gear_d)
      4'd0:    led_d = 7'b0000001;
      4'd1:    led_d = 7'b1001111;
      4'd2:    led_d = 7'b0010010;
      4'd3:    led_d = 7'b0000110;
      4'd4:    led_d = 7'b1001100;
      4'd5:    led_d = 7'b0100100;
      4'd6:    led_d = 7'b0100000;
      4'd7:    led_d = 7'b0001111;
      4'd8:    led_d = 7'b0000000;
      4'd9:    led_d = 7'b0000100;
      4'd15:   led_d = 7'b1111010;
      default: led_d = 7'b1111111;
    endcase
    turn_ok = (state_d == ST_REV) || (gear_d < 4'(TURN_LIMIT));
    lh_en   = key && !brake && l && !r && turn_ok;
    rh_en   = key && !brake && r && !l && turn_ok;
    lh_d    = lh_en && blink_d;
    rh_d    = rh_en && blink_d;
    m2_d    = lh_en ? 2'd2 : (rh_en ? 2'd1 : 2'd0);
    tl_d    = (state_d == ST_REV) ? blink_d : (brake && key);
    hl_d    = hl && key;
    al_d    = acc && key;
    e_d     = key;
    if (!key)                   an_d = 4'b1111;
    else if (state_d == ST_REV) an_d = {4{~blink_d}};
    else                        an_d = 4'b1110;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PARK;
      speed_q <= 7'd0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
      gear_q  <= 4'd0;
      led_q   <= 7'b0000001;
      an_q    <= 4'b1111;
      m2_q    <= 2'd0;
      e_q     <= 1'b0;
      tl_q    <= 1'b0;
      lh_q    <= 1'b0;
      rh_q    <= 1'b0;
      hl_q    <= 1'b0;
      al_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      gear_q  <= gear_d;
      led_q   <= led_d;
      an_q    <= an_d;
      m2_q    <= m2_d;
      e_q     <= e_d;
      tl_q    <= tl_d;
      lh_q    <= lh_d;
      rh_q    <= rh_d;
      hl_q    <= hl_d;
      al_q    <= al_d;
      tick_q  <= tick_d;
    end
  end

  assign speed  = speed_q;
  assign gear_o = gear_q;
  assign LED    = led_q;
  assign AN     = an_q;
  assign M2     = m2_q;
  assign E      = e_q;
  assign TL     = tl_q;
  assign LH     = lh_q;
  assign RH     = rh_q;
  assign HL     = hl_q;
  assign AL     = al_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_drive_gear_ctrl.sv
// Bench for drive_gear_ctrl: directed scenarios plus randomized traffic against a tick-level model.
// Cruise checks are compiled in when DRIVE_CRUISE_EN is defined.
module tb_drive_gear_ctrl;
  localparam int TD = 4, NG = 5, GS = 5, ACC = 3, CST = 1, BRK = 3, TLIM = 4, RMAX = 5;
  localparam int PARK = 0, FWD = 1, REV = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic key = 1'b0, brake = 1'b0, acc = 1'b0, gear = 1'b0, l = 1'b0, r = 1'b0, hl = 1'b0;
`ifdef DRIVE_CRUISE_EN
  logic cruise = 1'b0;
`endif
  logic [6:0] speed, LED;
  logic [3:0] gear_o, AN;
  logic [1:0] M2;
  logic       E, TL, LH, RH, HL, AL, tick;

  drive_gear_ctrl #(
    .TICK_DIV(TD), .NUM_GEARS(NG), .GEAR_STEP(GS), .ACC_STEP(ACC), .COAST_STEP(CST),
    .BRAKE_STEP(BRK), .TURN_LIMIT(TLIM), .REV_MAX(RMAX)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .brake(brake), .acc(acc), .gear(gear),
    .l(l), .r(r), .hl(hl),
`ifdef DRIVE_CRUISE_EN
    .cruise(cruise),
`endif
    .speed(speed), .gear_o(gear_o), .E(E), .TL(TL), .LH(LH), .RH(RH), .HL(HL), .AL(AL),
    .M2(M2), .AN(AN), .LED(LED), .tick(tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int m_state, m_speed, m_blink, m_cnt, m_cruise, m_cprev, m_ticks;
  int m_wrap;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int led_of(input int g);
    case (g)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      15: return 7'b1111010;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int gear_of(input int st, input int sp);
    if (st == REV) return 15;
    return (sp / GS > NG) ? NG : sp / GS;
  endfunction

  task automatic model_reset();
    m_state = PARK; m_speed = 0; m_blink = 0; m_cnt = 0;
    m_cruise = 0; m_cprev = 0; m_wrap = 0;
  endtask

  // One clock edge of the vehicle rules: speed and state move only on the tick.
  task automatic model_edge();
    int old_st = m_state;
    int old_sp = m_speed;
    int nst, lim;
    m_wrap = (m_cnt == TD - 1) ? 1 : 0;
    m_cnt  = (m_wrap != 0) ? 0 : m_cnt + 1;
    if (m_wrap != 0) begin
      m_ticks++;
      m_blink = 1 - m_blink;
      nst = old_st;
      if (!key) nst = PARK;
      else if (old_st == PARK) nst = FWD;
      else if (old_st == FWD && gear && old_sp == 0) nst = REV;
      else if (old_st == REV && !gear && old_sp == 0) nst = FWD;
      if (!((old_st == FWD && nst == REV) || (old_st == REV && nst == FWD))) begin
        lim = (nst == REV) ? RMAX : NG * GS;
        if (nst == PARK || brake || (nst == FWD && gear)) m_speed = m_speed - BRK;
        else if (acc) m_speed = (m_speed + ACC > lim) ? lim : m_speed + ACC;
        else if (!(nst == FWD && m_cruise != 0)) m_speed = m_speed - CST;
        if (m_speed < 0) m_speed = 0;
      end
      m_state = nst;
    end
`ifdef DRIVE_CRUISE_EN
    if (cruise && m_cprev == 0)
      m_cruise = (m_cruise == 0 && old_st == FWD && old_sp > 0) ? 1 : 0;
    if (brake || !key || gear || old_st != FWD) m_cruise = 0;
    m_cprev = cruise ? 1 : 0;
`endif
  endtask

  task automatic compare_all();
    int g = gear_of(m_state, m_speed);
    int turn_ok = (m_state == REV || g < TLIM) ? 1 : 0;
    int lh = (key && !brake && l && !r && turn_ok != 0) ? 1 : 0;
    int rh = (key && !brake && r && !l && turn_ok != 0) ? 1 : 0;
    int an = !key ? 15 : (m_state == REV ? (m_blink != 0 ? 0 : 15) : 14);
    chk("speed", int'(speed), m_speed);
    chk("gear_o", int'(gear_o), g);
    chk("LED", int'(LED), led_of(g));
    chk("tick", int'(tick), m_wrap);
    chk("E", int'(E), int'(key));
    chk("TL", int'(TL), (m_state == REV) ? m_blink : int'(brake && key));
    chk("LH", int'(LH), lh * m_blink);
    chk("RH", int'(RH), rh * m_blink);
    chk("HL", int'(HL), int'(hl && key));
    chk("AL", int'(AL), int'(acc && key));
    chk("M2", int'(M2), lh != 0 ? 2 : (rh != 0 ? 1 : 0));
    chk("AN", int'(AN), an);
    if (m_wrap != 0)
      $display("tick %0d: state=%0d speed=%0d gear_o=%0d blink=%0d", m_ticks, m_state, m_speed, g, m_blink);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    int target = m_ticks + n;
    while (m_ticks < target) cycle();
  endtask

  // Called at a falling edge; reset pulses inside the low half-period.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_speed", int'(speed), 0);
    chk("rst_gear_o", int'(gear_o), 0);
    chk("rst_AN", int'(AN), 15);
    chk("rst_LED", int'(LED), 7'b0000001);
    chk("rst_lamps", int'({E, TL, LH, RH, HL, AL, tick}), 0);
    chk("rst_M2", int'(M2), 0);
    $display("reset at %0t", $time);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    int acc_pct, brk_pct, gear_pct;
    m_ticks = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Acceleration ramp from standstill, then saturation and braking (acc held: brake wins).
    key = 1'b1; acc = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      run_ticks(1);
      chk("acc_ramp", int'(speed), 3 * i);
    end
    chk("ramp_gear", int'(gear_o), 3);
    chk("ramp_LED", int'(LED), 7'b0000110);
    run_ticks(6);
    chk("sat_speed", int'(speed), 25);
    chk("sat_gear", int'(gear_o), 5);
    brake = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      run_ticks(1);
      chk("brake_down", int'(speed), (25 - 3 * i > 0) ? 25 - 3 * i : 0);
    end

    // Reverse request at speed 10 with accelerator held.
    brake = 1'b0;
    run_ticks(4);
    acc = 1'b0;
    run_ticks(2);
    chk("pre_rev_speed", int'(speed), 10);
    gear = 1'b1; acc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_ticks(1);
      chk("rev_brake", int'(speed), (7 - 3 * i > 0) ? 7 - 3 * i : 0);
    end
    run_ticks(1);
    chk("rev_gear", int'(gear_o), 15);
    chk("rev_LED", int'(LED), 7'b1111010);
    for (int i = 0; i < 3; i++) begin
      run_ticks(1);
      chk("rev_TL", int'(TL), m_blink);
      chk("rev_AN", int'(AN), m_blink != 0 ? 0 : 15);
    end
    gear = 1'b0; acc = 1'b0;

    // Turn indicator inhibited in gear 4, active in gear 3.
    do_reset();
    key = 1'b1; acc = 1'b1;
    run_ticks(7);
    acc = 1'b0;
    run_ticks(1);
    chk("turn_speed20", int'(speed), 20);
    l = 1'b1;
    cycle();
    cycle();
    chk("g4_LH", int'(LH), 0);
    chk("g4_M2", int'(M2), 0);
    for (int i = 0; i < 2; i++) begin
      run_ticks(1);
      chk("g3_gear", int'(gear_o), 3);
      chk("g3_LH", int'(LH), m_blink);
      chk("g3_M2", int'(M2), 2);
    end
    l = 1'b0;

    // Reset in the middle of a tick period at speed 12.
    do_reset();
    key = 1'b1; acc = 1'b1;
    run_ticks(4);
    chk("mid_speed12", int'(speed), 12);
    cycle();
    cycle();
    do_reset();
    n = 0; seen = 0;
    while (seen == 0 && n < 20) begin
      cycle();
      n++;
      if (tick) seen = 1;
    end
    chk("tick_after_rst", n, 4);

`ifdef DRIVE_CRUISE_EN
    do_reset();
    key = 1'b1; acc = 1'b1;
    run_ticks(5);
    acc = 1'b0; cruise = 1'b1;
    cycle();
    cruise = 1'b0;
    run_ticks(5);
    chk("cruise_hold", int'(speed), 15);
    brake = 1'b1;
    run_ticks(1);
    chk("cruise_brake", int'(speed), 12);
    brake = 1'b0;
    run_ticks(1);
    chk("cruise_cleared", int'(speed), 11);
`endif

    // Randomized traffic with per-segment input biases.
    acc_pct = 50; brk_pct = 20; gear_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        acc_pct  = $urandom_range(80, 10);
        brk_pct  = $urandom_range(40, 0);
        gear_pct = $urandom_range(60, 0);
      end
      key   = ($urandom_range(99, 0) < 97);
      brake = ($urandom_range(99, 0) < brk_pct);
      acc   = ($urandom_range(99, 0) < acc_pct);
      gear  = ($urandom_range(99, 0) < gear_pct);
      l     = ($urandom_range(99, 0) < 30);
      r     = ($urandom_range(99, 0) < 30);
      hl    = ($urandom_range(1, 0) == 1);
`ifdef DRIVE_CRUISE_EN
      cruise = ($urandom_range(99, 0) < 5);
`endif
      if ($urandom_range(499, 0) == 0) do_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
